// File: rtl/load_sense_controller.sv
// Load-sensing initiator: raises sense_start, retries on timeout and classifies the load by response latency.
// Outputs are registered or decoded from the state register; load_ok follows load_ready by one edge; no backpressure.
module load_sense_controller #(
  parameter int TIMEOUT    = 32,
  parameter int MAX_RETRY  = 2,
  parameter int GAP_CYCLES = 4,
  parameter int SMALL_MAX  = 8,
  parameter int MED_MAX    = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cycle_req,
  input  logic       door_closed,
  input  logic       abort,
  input  logic       load_ready,
  output logic       sense_start,
  output logic       busy,
  output logic       load_ok,
  output logic       load_fault,
  output logic [1:0] fault_code,
  output logic [1:0] load_class,
  output logic [1:0] retry_count
);

  typedef enum logic [2:0] {IDLE, SENSE, GAP, DONE, FAULT} state_t;

  localparam logic [1:0] CODE_NONE    = 2'd0;
  localparam logic [1:0] CODE_TIMEOUT = 2'd1;
  localparam logic [1:0] CODE_DOOR    = 2'd2;
  localparam logic [1:0] CODE_ABORT   = 2'd3;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] SMALL_LIM = 8'(SMALL_MAX);
  localparam logic [7:0] MED_LIM   = 8'(MED_MAX);
  localparam logic [1:0] RETRY_LIM = 2'(MAX_RETRY);

  state_t     state;
  logic [7:0] wait_cnt;
  logic [7:0] gap_cnt;

  // Latency in SENSE cycles before load_ready maps directly to load size.
  function automatic logic [1:0] classify(input logic [7:0] w);
    if (w < SMALL_LIM) begin
      return 2'd0;
    end else if (w < MED_LIM) begin
      return 2'd1;
    end else begin
      return 2'd2;
    end
  endfunction

  assign sense_start = (state == SENSE);
  assign busy        = (state != IDLE);
  assign load_ok     = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= 8'd0;
      gap_cnt     <= 8'd0;
      load_fault  <= 1'b0;
      fault_code  <= CODE_NONE;
      load_class  <= 2'd0;
      retry_count <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (cycle_req) begin
            if (door_closed) begin
              state       <= SENSE;
              wait_cnt    <= 8'd0;
              retry_count <= 2'd0;
              load_fault  <= 1'b0;
              fault_code  <= CODE_NONE;
            end else begin
              state      <= FAULT;
              load_fault <= 1'b1;
              fault_code <= CODE_DOOR;
            end
          end
        end

        SENSE: begin
          wait_cnt <= wait_cnt + 8'd1;
          if (abort) begin
            state      <= FAULT;
            load_fault <= 1'b1;
            fault_code <= CODE_ABORT;
          end else if (!door_closed) begin
            state      <= FAULT;
            load_fault <= 1'b1;
            fault_code <= CODE_DOOR;
          end else if (load_ready) begin
            state      <= DONE;
            load_class <= classify(wait_cnt);
          end else if (wait_cnt == WAIT_LAST) begin
            if (retry_count < RETRY_LIM) begin
              state       <= GAP;
              gap_cnt     <= 8'd0;
              retry_count <= retry_count + 2'd1;
            end else begin
              state      <= FAULT;
              load_fault <= 1'b1;
              fault_code <= CODE_TIMEOUT;
            end
          end
        end

        // load_ready is deliberately not looked at while the sensor is idle.
        GAP: begin
          gap_cnt <= gap_cnt + 8'd1;
          if (abort) begin
            state      <= FAULT;
            load_fault <= 1'b1;
            fault_code <= CODE_ABORT;
          end else if (!door_closed) begin
            state      <= FAULT;
            load_fault <= 1'b1;
            fault_code <= CODE_DOOR;
          end else if (gap_cnt == GAP_LAST) begin
            state    <= SENSE;
            wait_cnt <= 8'd0;
          end
        end

        DONE:    state <= IDLE;
        FAULT:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_sense_controller.sv
// Directed bench for load_sense_controller: a spec-level model pushes expected results,
// the per-request monitor pushes observations, and drain() compares them in order.
module tb_load_sense_controller;

  localparam int TIMEOUT    = 32;
  localparam int MAX_RETRY  = 2;
  localparam int GAP_CYCLES = 4;
  localparam int SMALL_MAX  = 8;
  localparam int MED_MAX    = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       cycle_req;
  logic       door_closed;
  logic       abort;
  logic       load_ready;
  logic       sense_start;
  logic       busy;
  logic       load_ok;
  logic       load_fault;
  logic [1:0] fault_code;
  logic [1:0] load_class;
  logic [1:0] retry_count;

  load_sense_controller #(
    .TIMEOUT    (TIMEOUT),
    .MAX_RETRY  (MAX_RETRY),
    .GAP_CYCLES (GAP_CYCLES),
    .SMALL_MAX  (SMALL_MAX),
    .MED_MAX    (MED_MAX)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cycle_req   (cycle_req),
    .door_closed (door_closed),
    .abort       (abort),
    .load_ready  (load_ready),
    .sense_start (sense_start),
    .busy        (busy),
    .load_ok     (load_ok),
    .load_fault  (load_fault),
    .fault_code  (fault_code),
    .load_class  (load_class),
    .retry_count (retry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [7:0] val;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] obs_q[$];
  int         compared   = 0;
  int         mismatched = 0;

  // Model state carried across requests (held class / retries).
  int m_cls   = 0;
  int m_retry = 0;

  task automatic expect_val(input string tag, input int v);
    exp_t e;
    e.tag = tag;
    e.val = 8'(v);
    exp_q.push_back(e);
  endtask

  task automatic expect_zero_outs();
    expect_val("sense_start", 0);
    expect_val("busy", 0);
    expect_val("load_ok", 0);
    expect_val("load_fault", 0);
    expect_val("fault_code", 0);
    expect_val("load_class", 0);
    expect_val("retry_count", 0);
  endtask

  task automatic push_outs();
    obs_q.push_back(8'(sense_start));
    obs_q.push_back(8'(busy));
    obs_q.push_back(8'(load_ok));
    obs_q.push_back(8'(load_fault));
    obs_q.push_back(8'(fault_code));
    obs_q.push_back(8'(load_class));
    obs_q.push_back(8'(retry_count));
  endtask

  task automatic drain();
    exp_t       e;
    logic [7:0] o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() > 0) o = obs_q.pop_front();
      else                  o = 8'hxx;
      compared++;
      assert (o === e.val) else begin
        mismatched++;
        $error("FAIL %s: observed %0d, expected %0d", e.tag, o, e.val);
      end
    end
    compared++;
    assert (obs_q.size() == 0) else begin
      mismatched++;
      $error("FAIL extra_observations: observed %0d leftover, expected 0", obs_q.size());
    end
    obs_q.delete();
  endtask

  // Spec-level model of one request: window lengths, gaps and final outputs.
  task automatic model_req(input int rdy_att, input int rdy_cyc, input int ev_att,
                           input int ev_cyc, input int ev_abort, input int door_open_req);
    int wins[$];
    int gaps[$];
    int ok    = 0;
    int fault = 0;
    int code  = 0;
    if (door_open_req != 0) begin
      fault = 1;
      code  = 2;
    end else begin
      m_retry = 0;
      for (int a = 1; a <= MAX_RETRY + 1; a++) begin
        int len;
        int kind;
        len  = TIMEOUT;
        kind = 0;
        if (rdy_att == a && rdy_cyc < TIMEOUT) begin
          len  = rdy_cyc + 1;
          kind = 1;
        end
        if (ev_att == a && ev_cyc < TIMEOUT && ev_cyc + 1 <= len) begin
          len  = ev_cyc + 1;
          kind = 2;
        end
        wins.push_back(len);
        if (kind == 1) begin
          ok    = 1;
          m_cls = (rdy_cyc < SMALL_MAX) ? 0 : (rdy_cyc < MED_MAX) ? 1 : 2;
          break;
        end
        if (kind == 2) begin
          fault = 1;
          code  = (ev_abort != 0) ? 3 : 2;
          break;
        end
        if (a <= MAX_RETRY) begin
          m_retry++;
          gaps.push_back(GAP_CYCLES);
        end else begin
          fault = 1;
          code  = 1;
        end
      end
    end
    expect_val("load_ok_pulses", ok);
    expect_val("load_class", m_cls);
    expect_val("retry_count", m_retry);
    expect_val("load_fault", fault);
    expect_val("fault_code", code);
    expect_val("busy_after", 0);
    expect_val("num_windows", wins.size());
    foreach (wins[i]) expect_val("window_len", wins[i]);
    expect_val("num_gaps", gaps.size());
    foreach (gaps[i]) expect_val("gap_len", gaps[i]);
  endtask

  // Drives one request and acts as the sensor; inputs change on the falling edge.
  task automatic run_req(input int rdy_att, input int rdy_cyc, input int ev_att,
                         input int ev_cyc, input int ev_abort, input int door_open_req,
                         input int gap_pulse, input int rst_att, input int rst_cyc);
    int win_q[$];
    int gap_q[$];
    int att     = 0;
    int win     = 0;
    int gap     = 0;
    int okc     = 0;
    bit prev_ss = 1'b0;
    bit started = 1'b0;
    bit done    = 1'b0;
    bit rst_hit = 1'b0;
    @(negedge clk);
    door_closed = (door_open_req == 0);
    cycle_req   = 1'b1;
    for (int t = 0; t < 600 && !done; t++) begin
      @(negedge clk);
      cycle_req   = 1'b0;
      load_ready  = 1'b0;
      abort       = 1'b0;
      door_closed = 1'b1;
      if (busy)    started = 1'b1;
      if (load_ok) okc++;
      if (sense_start) begin
        if (!prev_ss) begin
          att++;
          win = 0;
          if (gap > 0) gap_q.push_back(gap);
          gap = 0;
        end
        if (att == rst_att && win == rst_cyc) begin
          #2 reset = 1'b1;
          #1 push_outs();
          rst_hit = 1'b1;
          done    = 1'b1;
        end else begin
          if (att == rdy_att && win == rdy_cyc) load_ready = 1'b1;
          if (att == ev_att && win == ev_cyc) begin
            abort       = (ev_abort != 0);
            door_closed = 1'b0;
          end
          win++;
        end
      end else begin
        if (prev_ss) win_q.push_back(win);
        if (busy && !load_ok && !load_fault) begin
          gap++;
          if (gap_pulse != 0 && gap == 2) load_ready = 1'b1;
        end
        if (started && !busy) done = 1'b1;
      end
      prev_ss = sense_start;
    end
    compared++;
    assert (done) else begin
      mismatched++;
      $error("FAIL request_completion: observed still busy, expected return to IDLE within 600 cycles");
    end
    if (!rst_hit) begin
      obs_q.push_back(8'(okc));
      obs_q.push_back(8'(load_class));
      obs_q.push_back(8'(retry_count));
      obs_q.push_back(8'(load_fault));
      obs_q.push_back(8'(fault_code));
      obs_q.push_back(8'(busy));
      obs_q.push_back(8'(win_q.size()));
      foreach (win_q[i]) obs_q.push_back(8'(win_q[i]));
      obs_q.push_back(8'(gap_q.size()));
      foreach (gap_q[i]) obs_q.push_back(8'(gap_q[i]));
    end
  endtask

  task automatic ready_case(input int att, input int cyc, input int gap_pulse);
    model_req(att, cyc, 0, 0, 0, 0);
    run_req(att, cyc, 0, 0, 0, 0, gap_pulse, 0, 0);
    drain();
  endtask

  initial begin
    reset       = 1'b1;
    cycle_req   = 1'b0;
    door_closed = 1'b1;
    abort       = 1'b0;
    load_ready  = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    expect_zero_outs();
    push_outs();
    drain();
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Ready at SENSE cycle 5, 20, 12 and around the class boundaries.
    ready_case(1, 5, 0);
    ready_case(1, 20, 0);
    ready_case(1, 12, 0);
    ready_case(1, SMALL_MAX - 1, 0);
    ready_case(1, SMALL_MAX, 0);
    ready_case(1, MED_MAX - 1, 0);
    ready_case(1, MED_MAX, 0);
    ready_case(1, TIMEOUT - 1, 0);

    // Sensor never answers: three full windows, then timeout fault.
    ready_case(0, 0, 0);

    // Ready in the second attempt; a load_ready pulse in GAP must be ignored.
    ready_case(2, 3, 1);

    // Door opens together with abort at SENSE cycle 10: abort wins.
    model_req(0, 0, 1, 10, 1, 0);
    run_req(0, 0, 1, 10, 1, 0, 0, 0, 0);
    drain();

    // Door opens alone in a later attempt.
    model_req(0, 0, 2, 6, 0, 0);
    run_req(0, 0, 2, 6, 0, 0, 0, 0, 0);
    drain();

    // Request with the door open: fault 2, sense_start never rises.
    model_req(0, 0, 0, 0, 0, 1);
    run_req(0, 0, 0, 0, 0, 1, 0, 0, 0);
    drain();

    // Leftover fault clears on the next accepted request.
    ready_case(1, 14, 0);

    // Asynchronous reset mid-SENSE in the second attempt drops everything at once.
    expect_zero_outs();
    run_req(0, 0, 0, 0, 0, 0, 0, 2, 3);
    drain();
    @(negedge clk);
    reset   = 1'b0;
    m_cls   = 0;
    m_retry = 0;
    repeat (2) @(negedge clk);
    expect_zero_outs();
    push_outs();
    drain();

    // Normal operation after reset.
    ready_case(1, 9, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/load_sense_controller.md
# load_sense_controller

Initiator side of the load-sensing handshake. On a user cycle request it drives `sense_start` to the load-sensing block, then waits for `load_ready` under a timeout with bounded retries. It classifies the load size from the measured response latency and reports success or a coded fault to the wash-cycle controller. It sits between the front-panel start logic and the load-sensing block.

## Interface
- `TIMEOUT`, 32: max SENSE cycles per attempt without `load_ready` (2..255)
- `MAX_RETRY`, 2: retries after the first timed-out attempt (0..3)
- `GAP_CYCLES`, 4: cycles `sense_start` is held low between attempts (1..255)
- `SMALL_MAX`, 8: latency below this → class small
- `MED_MAX`, 16: latency below this (and ≥ `SMALL_MAX`) → class medium
- `clk` in 1: clock, rising edge
- `reset` in 1: reset, asynchronous, active-high
- `cycle_req` in 1: request to start sensing, sampled only in IDLE
- `door_closed` in 1: door interlock, level
- `abort` in 1: cancel request, level
- `load_ready` in 1: from the load-sensing block, level
- `sense_start` out 1: to the load-sensing block, held high while sensing
- `busy` out 1: high in every state except IDLE
- `load_ok` out 1: one-cycle pulse on success
- `load_fault` out 1: sticky fault flag
- `fault_code` out 2: 0 none, 1 timeout, 2 door open, 3 abort
- `load_class` out 2: 0 small, 1 medium, 2 large; 3 unused
- `retry_count` out 2: retries consumed in the current or last request

## Operation
- Moore FSM with states IDLE, SENSE, GAP, DONE, FAULT. All outputs are registered or decoded from the state register.
- `sense_start` = (state == SENSE). `busy` = (state != IDLE). `load_ok` = (state == DONE).
- `wait_cnt` is 8 bits. It is cleared on every entry to SENSE and increments each SENSE cycle. Its value is 0 in the first SENSE cycle.
- `gap_cnt` is 8 bits. It is cleared on entry to GAP.
- IDLE:
  - `cycle_req` & `door_closed`: go to SENSE; clear `retry_count`; clear `load_fault` and `fault_code`; hold `load_class`.
  - `cycle_req` & !`door_closed`: go to FAULT with code 2.
- SENSE, evaluated in this priority order:
  1. `abort`: go to FAULT, code 3.
  2. !`door_closed`: go to FAULT, code 2.
  3. `load_ready`: go to DONE; latch `load_class` from the current `wait_cnt`.
  4. `wait_cnt` == `TIMEOUT`-1: if `retry_count` < `MAX_RETRY`, increment `retry_count` and go to GAP; otherwise go to FAULT, code 1.
- GAP:
  - `abort` or !`door_closed`: go to FAULT with code 3 or 2 respectively; abort wins.
  - `gap_cnt` == `GAP_CYCLES`-1: go to SENSE.
  - `load_ready` is ignored in GAP.
- DONE: one cycle, then IDLE.
- FAULT: set `load_fault` = 1 and latch `fault_code`; one cycle, then IDLE. `load_fault` and `fault_code` persist until the next accepted request.
- Classification, from the latched `wait_cnt` value w:
  - w < `SMALL_MAX` → 0
  - w < `MED_MAX` → 1
  - otherwise → 2
- `abort` in IDLE, DONE or FAULT has no effect.

## Timing
- Reset values: state IDLE, `sense_start` 0, `busy` 0, `load_ok` 0, `load_fault` 0, `fault_code` 0, `load_class` 0, `retry_count` 0.
- Reset is asynchronous. Asserting it mid-SENSE drops `sense_start` immediately and produces no `load_ok` or fault.
- `cycle_req` sampled high at edge k → `sense_start` and `busy` high from edge k through the edge that leaves SENSE.
- `load_ready` sampled high at edge k+1+w (w = `wait_cnt`) → `load_ok` high for the cycle after that edge; `busy` drops one cycle later.
- Worst-case attempt: `TIMEOUT` SENSE cycles plus `GAP_CYCLES` low cycles.
- A held `cycle_req` re-triggers a new request on the first IDLE cycle after DONE or FAULT.

## Test plan
- Defaults; sensor model raises `load_ready` at SENSE cycle 5 → `load_ok` pulses once, `load_class`=0, `retry_count`=0, `sense_start` high for exactly 6 cycles.
- Sensor ready at SENSE cycle 20 → `load_class`=2. Ready at cycle 12 → `load_class`=1.
- Sensor never ready → three SENSE windows of 32 cycles, each separated by 4 low cycles; then `load_fault`=1, `fault_code`=1, `retry_count`=2, `busy` low.
- Ready only in the second attempt at cycle 3 → `load_ok`, `retry_count`=1, `load_class`=0. `load_ready` pulsed during GAP is ignored.
- `door_closed` drops at SENSE cycle 10 with `abort` high in the same cycle → `fault_code`=3. A later `cycle_req` with door open → `fault_code`=2 and `sense_start` never rises.
- `reset` asserted mid-SENSE → all outputs are 0 immediately. A fault left over from a prior request clears on the next accepted `cycle_req`.
